// File: rtl/mem_arbi_pkg.sv
// Shared definitions for the memory-side burst arbiters: FSM state encoding
// and the priority-mode constants used by both the write and read variants.
package mem_arbi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_BEGIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_END   = 3'd4
    } arb_state_t;

    // Values accepted by the PRIO_MODE parameter of the arbiter tops.
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // One-bit mode selector carried into the arbitration sub-module.
    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel picker. Given the eligible vector it returns a one-hot
// winner, searching either from the round-robin pointer (wrapping) or from
// channel 0 (fixed priority). The parent registers the result.
module rr_arbiter
    import mem_arbi_pkg::*;
#(
    parameter int CH_NUM = 6,
    parameter int PTR_W  = 3
) (
    input  logic [CH_NUM-1:0] i_eligible,
    input  logic [PTR_W-1:0]  i_rr_ptr,
    input  logic              i_mode,
    output logic [CH_NUM-1:0] o_winner
);

    logic [CH_NUM-1:0] w_rot;
    logic [CH_NUM-1:0] w_iso_rr;
    logic [CH_NUM-1:0] w_win_rr;
    logic [CH_NUM-1:0] w_win_fixed;

    // Rotate the request vector so the pointer channel sits at bit 0; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_rot    = CH_NUM'({i_eligible, i_eligible} >> i_rr_ptr);
    assign w_iso_rr = w_rot & (-w_rot);

    // Rotate the isolated bit back into channel numbering.
    assign w_win_rr = CH_NUM'(({w_iso_rr, w_iso_rr} << i_rr_ptr) >> CH_NUM);

    // Fixed priority is simply the lowest set bit of the unrotated vector.
    assign w_win_fixed = i_eligible & (-i_eligible);

    assign o_winner = (i_mode == MODE_FIXED) ? w_win_fixed : w_win_rr;

endmodule

// File: rtl/mem_write_arbi_rr.sv
// Write-side burst arbiter: multiplexes CH_NUM write channels onto a single
// memory-controller burst interface, with round-robin or fixed priority and a
// per-burst watchdog that aborts bursts the controller never finishes.
module mem_write_arbi_rr
    import mem_arbi_pkg::*;
#(
    parameter int MEM_DATA_BITS  = 32,
    parameter int ADDR_BITS      = 23,
    parameter int BURST_BITS     = 10,
    parameter int CH_NUM         = 6,
    parameter int PRIO_MODE      = 0,
    parameter int TIMEOUT_CYCLES = 8000
) (
    input  logic                            mem_clk,
    input  logic                            rst_n,

    input  logic [CH_NUM-1:0]               ch_wr_burst_req,
    input  logic [CH_NUM*BURST_BITS-1:0]    ch_wr_burst_len,
    input  logic [CH_NUM*ADDR_BITS-1:0]     ch_wr_burst_addr,
    input  logic [CH_NUM*MEM_DATA_BITS-1:0] ch_wr_burst_data,
    output logic [CH_NUM-1:0]               ch_wr_burst_data_req,
    output logic [CH_NUM-1:0]               ch_wr_burst_finish,

    output logic                            wr_burst_req,
    output logic [BURST_BITS-1:0]           wr_burst_len,
    output logic [ADDR_BITS-1:0]            wr_burst_addr,
    input  logic                            wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0]        wr_burst_data,
    input  logic                            wr_burst_finish,

    output logic [CH_NUM-1:0]               grant,
    output logic                            timeout_pulse
);

    localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] LP_PTR_LAST = PTR_W'(CH_NUM - 1);
    localparam logic LP_MODE = (PRIO_MODE == PRIO_FIXED) ? MODE_FIXED : MODE_RR;

    arb_state_t             r_state;
    logic [CH_NUM-1:0]      r_grant;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]       r_wd_cnt;
    logic                   r_wr_burst_req;
    logic [BURST_BITS-1:0]  r_wr_burst_len;
    logic [ADDR_BITS-1:0]   r_wr_burst_addr;
    logic                   r_timeout_pulse;

    logic [CH_NUM-1:0]      w_eligible;
    logic [CH_NUM-1:0]      w_winner;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [PTR_W-1:0]       w_next_ptr;

    // OR-reduction chains that select the granted channel's fields.
    logic [BURST_BITS-1:0]    w_len_or  [0:CH_NUM];
    logic [ADDR_BITS-1:0]     w_addr_or [0:CH_NUM];
    logic [MEM_DATA_BITS-1:0] w_data_or [0:CH_NUM];
    logic [PTR_W-1:0]         w_idx_or  [0:CH_NUM];

    assign w_len_or[0]  = '0;
    assign w_addr_or[0] = '0;
    assign w_data_or[0] = '0;
    assign w_idx_or[0]  = '0;

    // Per-channel eligibility (a zero-length request is never served) and
    // one-hot selection of the granted channel's length, address and data.
    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        assign w_eligible[g] = ch_wr_burst_req[g] &&
                               (ch_wr_burst_len[g*BURST_BITS +: BURST_BITS] != '0);
        assign w_len_or[g+1]  = w_len_or[g] |
                                (r_grant[g] ? ch_wr_burst_len[g*BURST_BITS +: BURST_BITS] : '0);
        assign w_addr_or[g+1] = w_addr_or[g] |
                                (r_grant[g] ? ch_wr_burst_addr[g*ADDR_BITS +: ADDR_BITS] : '0);
        assign w_data_or[g+1] = w_data_or[g] |
                                (r_grant[g] ? ch_wr_burst_data[g*MEM_DATA_BITS +: MEM_DATA_BITS] : '0);
        assign w_idx_or[g+1]  = w_idx_or[g] | (r_grant[g] ? PTR_W'(g) : '0);
    end

    assign w_grant_idx = w_idx_or[CH_NUM];
    assign w_next_ptr  = (w_grant_idx == LP_PTR_LAST) ? '0 : w_grant_idx + 1'b1;

    rr_arbiter #(
        .CH_NUM (CH_NUM),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .i_mode     (LP_MODE),
        .o_winner   (w_winner)
    );

    // Burst sequencing FSM: pick a channel, issue its request, watch the data
    // phase with the watchdog, then hand the bus back and advance the pointer.
    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_grant         <= '0;
            r_rr_ptr        <= '0;
            r_wd_cnt        <= '0;
            r_wr_burst_req  <= 1'b0;
            r_wr_burst_len  <= '0;
            r_wr_burst_addr <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ARB;
                end
                ST_ARB: begin
                    if (|w_winner) begin
                        r_grant  <= w_winner;
                        r_wd_cnt <= '0;
                        r_state  <= ST_BEGIN;
                    end
                end
                ST_BEGIN: begin
                    r_wr_burst_len  <= w_len_or[CH_NUM];
                    r_wr_burst_addr <= w_addr_or[CH_NUM];
                    r_wr_burst_req  <= 1'b1;
                    r_state         <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_burst_data_req) begin
                        r_wr_burst_req <= 1'b0;
                    end
                    if (wr_burst_finish) begin
                        r_state <= ST_END;
                    end else if (r_wd_cnt == LP_TO_LAST) begin
                        r_state         <= ST_ARB;
                        r_timeout_pulse <= 1'b1;
                        r_wr_burst_req  <= 1'b0;
                        r_grant         <= '0;
                        r_rr_ptr        <= w_next_ptr;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                ST_END: begin
                    r_wr_burst_req <= 1'b0;
                    r_grant        <= '0;
                    r_rr_ptr       <= w_next_ptr;
                    r_state        <= ST_ARB;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant         = r_grant;
    assign wr_burst_req  = r_wr_burst_req;
    assign wr_burst_len  = r_wr_burst_len;
    assign wr_burst_addr = r_wr_burst_addr;
    assign timeout_pulse = r_timeout_pulse;

    assign wr_burst_data        = (r_state == ST_WRITE) ? w_data_or[CH_NUM] : '0;
    assign ch_wr_burst_data_req = (r_state == ST_WRITE && wr_burst_data_req) ? r_grant : '0;
    assign ch_wr_burst_finish   = (r_state == ST_END) ? r_grant : '0;

endmodule

// File: tb/tb_mem_write_arbi_rr.sv
// Bench for mem_write_arbi_rr: a round-robin and a fixed-priority instance
// share the channel inputs and a simple controller model driven by the bench.
module tb_mem_write_arbi_rr;

    localparam int CH = 6;
    localparam int DW = 32;
    localparam int AW = 23;
    localparam int BW = 10;
    localparam int TO = 16;

    typedef struct {
        bit            doReset;
        bit            useFp;
        logic [CH-1:0] req;
        logic [CH-1:0] zeroLen;
        logic [BW-1:0] lenVal;
        int            expCh;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rstN;
    logic [CH-1:0]    chReq;
    logic [CH*BW-1:0] chLen;
    logic [CH*AW-1:0] chAddr;
    logic [CH*DW-1:0] chData;
    logic             dataReq;
    logic             finish;

    logic [CH-1:0] rrChDataReq, rrChFinish, rrGrant;
    logic          rrBurstReq, rrTimeout;
    logic [BW-1:0] rrBurstLen;
    logic [AW-1:0] rrBurstAddr;
    logic [DW-1:0] rrBurstData;

    logic [CH-1:0] fpChDataReq, fpChFinish, fpGrant;
    logic          fpBurstReq, fpTimeout;
    logic [BW-1:0] fpBurstLen;
    logic [AW-1:0] fpBurstAddr;
    logic [DW-1:0] fpBurstData;

    logic          useFpSel;
    logic [CH-1:0] selChDataReq, selChFinish, selGrant;
    logic          selBurstReq, selTimeout;
    logic [BW-1:0] selBurstLen;
    logic [AW-1:0] selBurstAddr;
    logic [DW-1:0] selBurstData;

    int checks   = 0;
    int failures = 0;

    mem_write_arbi_rr #(
        .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_BITS(BW), .CH_NUM(CH),
        .PRIO_MODE(0), .TIMEOUT_CYCLES(TO)
    ) u_rr (
        .mem_clk(clk), .rst_n(rstN),
        .ch_wr_burst_req(chReq), .ch_wr_burst_len(chLen),
        .ch_wr_burst_addr(chAddr), .ch_wr_burst_data(chData),
        .ch_wr_burst_data_req(rrChDataReq), .ch_wr_burst_finish(rrChFinish),
        .wr_burst_req(rrBurstReq), .wr_burst_len(rrBurstLen),
        .wr_burst_addr(rrBurstAddr), .wr_burst_data_req(dataReq),
        .wr_burst_data(rrBurstData), .wr_burst_finish(finish),
        .grant(rrGrant), .timeout_pulse(rrTimeout)
    );

    mem_write_arbi_rr #(
        .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_BITS(BW), .CH_NUM(CH),
        .PRIO_MODE(1), .TIMEOUT_CYCLES(TO)
    ) u_fp (
        .mem_clk(clk), .rst_n(rstN),
        .ch_wr_burst_req(chReq), .ch_wr_burst_len(chLen),
        .ch_wr_burst_addr(chAddr), .ch_wr_burst_data(chData),
        .ch_wr_burst_data_req(fpChDataReq), .ch_wr_burst_finish(fpChFinish),
        .wr_burst_req(fpBurstReq), .wr_burst_len(fpBurstLen),
        .wr_burst_addr(fpBurstAddr), .wr_burst_data_req(dataReq),
        .wr_burst_data(fpBurstData), .wr_burst_finish(finish),
        .grant(fpGrant), .timeout_pulse(fpTimeout)
    );

    // Route whichever instance is under test to the common checking tasks.
    always_comb begin
        selChDataReq = useFpSel ? fpChDataReq : rrChDataReq;
        selChFinish  = useFpSel ? fpChFinish  : rrChFinish;
        selGrant     = useFpSel ? fpGrant     : rrGrant;
        selBurstReq  = useFpSel ? fpBurstReq  : rrBurstReq;
        selTimeout   = useFpSel ? fpTimeout   : rrTimeout;
        selBurstLen  = useFpSel ? fpBurstLen  : rrBurstLen;
        selBurstAddr = useFpSel ? fpBurstAddr : rrBurstAddr;
        selBurstData = useFpSel ? fpBurstData : rrBurstData;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Each channel carries a recognisable address and data word.
    task automatic setChannels(input logic [CH-1:0] req, input logic [CH-1:0] zeroLen,
                               input logic [BW-1:0] lenVal);
        chReq = req;
        for (int i = 0; i < CH; i++) begin
            chLen[i*BW +: BW]  = zeroLen[i] ? '0 : lenVal;
            chAddr[i*AW +: AW] = AW'(i * 256 + 16);
            chData[i*DW +: DW] = 32'hD000_0000 | 32'(i);
        end
    endtask

    task automatic doReset();
        rstN    = 1'b0;
        dataReq = 1'b0;
        finish  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstGrant",     64'(rrGrant),     64'd0);
        checkOutput("rstBurstReq",  64'(rrBurstReq),  64'd0);
        checkOutput("rstBurstLen",  64'(rrBurstLen),  64'd0);
        checkOutput("rstBurstAddr", 64'(rrBurstAddr), 64'd0);
        checkOutput("rstBurstData", 64'(rrBurstData), 64'd0);
        checkOutput("rstTimeout",   64'(rrTimeout),   64'd0);
        checkOutput("rstFpGrant",   64'(fpGrant),     64'd0);
        rstN = 1'b1;
    endtask

    task automatic waitBurstReq(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (selBurstReq) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("burstReqWait", 64'd0, 64'd1);
    endtask

    // Controller model: wait for the request, stream len beats, then finish.
    task automatic runBurst(input int expCh, input logic [BW-1:0] expLen);
        logic [CH-1:0] expGrant;
        bit seen;
        expGrant = CH'(1) << expCh;
        waitBurstReq(seen);
        if (!seen) return;
        checkOutput("grant",     64'(selGrant),     64'(expGrant));
        checkOutput("burstLen",  64'(selBurstLen),  64'(expLen));
        checkOutput("burstAddr", 64'(selBurstAddr), 64'(expCh * 256 + 16));
        dataReq = 1'b1;
        #1;
        checkOutput("burstData",  64'(selBurstData), 64'(32'hD000_0000 | 32'(expCh)));
        checkOutput("chDataReq",  64'(selChDataReq), 64'(expGrant));
        repeat (int'(expLen)) @(posedge clk);
        @(negedge clk);
        dataReq = 1'b0;
        finish  = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        checkOutput("chFinish",  64'(selChFinish),  64'(expGrant));
        checkOutput("endTimeout", 64'(selTimeout),  64'd0);
        checkOutput("dataIdle",  64'(selBurstData), 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        useFpSel = v.useFp;
        if (v.doReset) doReset();
        setChannels(v.req, v.zeroLen, v.lenVal);
        runBurst(v.expCh, v.lenVal);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL simTimeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        vec_t vecs[$];
        bit   seen;
        bit   flag;
        int   pulseAt;

        rstN     = 1'b0;
        dataReq  = 1'b0;
        finish   = 1'b0;
        useFpSel = 1'b0;
        setChannels('0, '0, '0);

        // Round-robin over all six channels, then mixed patterns.
        vecs.push_back('{1'b1, 1'b0, 6'h3F, 6'h00, 10'd4, 0});
        vecs.push_back('{1'b0, 1'b0, 6'h3F, 6'h00, 10'd4, 1});
        vecs.push_back('{1'b0, 1'b0, 6'h3F, 6'h00, 10'd4, 2});
        vecs.push_back('{1'b0, 1'b0, 6'h3F, 6'h00, 10'd4, 3});
        vecs.push_back('{1'b0, 1'b0, 6'h3F, 6'h00, 10'd4, 4});
        vecs.push_back('{1'b0, 1'b0, 6'h3F, 6'h00, 10'd4, 5});
        vecs.push_back('{1'b0, 1'b0, 6'h3F, 6'h00, 10'd4, 0});
        vecs.push_back('{1'b0, 1'b0, 6'h24, 6'h00, 10'd3, 2});
        vecs.push_back('{1'b0, 1'b0, 6'h03, 6'h00, 10'd2, 0});
        vecs.push_back('{1'b0, 1'b0, 6'h0A, 6'h02, 10'd5, 3});
        vecs.push_back('{1'b0, 1'b0, 6'h21, 6'h00, 10'd1, 5});
        // Fixed priority: ch2 always beats ch4; zero-length ch0 is skipped.
        vecs.push_back('{1'b1, 1'b1, 6'h14, 6'h00, 10'd4, 2});
        vecs.push_back('{1'b0, 1'b1, 6'h14, 6'h00, 10'd4, 2});
        vecs.push_back('{1'b0, 1'b1, 6'h14, 6'h00, 10'd4, 2});
        vecs.push_back('{1'b0, 1'b1, 6'h3F, 6'h01, 10'd3, 1});

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Zero-length request is never granted; once it has length it wins.
        useFpSel = 1'b0;
        doReset();
        setChannels(6'b001000, 6'b001000, 10'd4);
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rrGrant != '0 || rrBurstReq || fpGrant != '0) flag = 1'b1;
        end
        checkOutput("len0NoGrant", 64'(flag), 64'd0);
        setChannels(6'b001000, 6'b000000, 10'd2);
        runBurst(3, 10'd2);

        // Watchdog abort with finish withheld, then the next channel is served.
        doReset();
        setChannels(6'b000011, 6'b000000, 10'd4);
        waitBurstReq(seen);
        checkOutput("toGrant", 64'(rrGrant), 64'd1);
        pulseAt = 0;
        flag    = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rrChFinish != '0) flag = 1'b1;
            if (rrTimeout) begin
                pulseAt = k;
                break;
            end
        end
        checkOutput("toDelay",    64'(pulseAt),    64'd16);
        checkOutput("toNoFinish", 64'(flag),       64'd0);
        checkOutput("toGrantClr", 64'(rrGrant),    64'd0);
        checkOutput("toReqClr",   64'(rrBurstReq), 64'd0);
        @(negedge clk);
        checkOutput("toOneShot",  64'(rrTimeout),  64'd0);
        runBurst(1, 10'd4);

        // Finish on the very cycle the watchdog would expire: normal end.
        doReset();
        setChannels(6'b000001, 6'b000000, 10'd4);
        waitBurstReq(seen);
        flag = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rrTimeout) flag = 1'b1;
        end
        checkOutput("edgeEarlyTo", 64'(flag), 64'd0);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        checkOutput("edgeFinish",  64'(rrChFinish), 64'd1);
        checkOutput("edgeTimeout", 64'(rrTimeout),  64'd0);
        @(negedge clk);
        checkOutput("edgeTimeout2", 64'(rrTimeout), 64'd0);

        // Reset pulse in the middle of a ch1 burst clears everything.
        doReset();
        setChannels(6'b000010, 6'b000000, 10'd4);
        waitBurstReq(seen);
        checkOutput("midGrant", 64'(rrGrant), 64'h2);
        dataReq = 1'b1;
        rstN    = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("midRstGrant",   64'(rrGrant),     64'd0);
        checkOutput("midRstReq",     64'(rrBurstReq),  64'd0);
        checkOutput("midRstLen",     64'(rrBurstLen),  64'd0);
        checkOutput("midRstAddr",    64'(rrBurstAddr), 64'd0);
        checkOutput("midRstData",    64'(rrBurstData), 64'd0);
        checkOutput("midRstDataReq", 64'(rrChDataReq), 64'd0);
        checkOutput("midRstFinish",  64'(rrChFinish),  64'd0);
        checkOutput("midRstTimeout", 64'(rrTimeout),   64'd0);
        dataReq = 1'b0;
        setChannels(6'b000011, 6'b000000, 10'd3);
        runBurst(0, 10'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
